// File: rtl/mmul_host_pkg.sv
// Shared types and constants for the matrix-multiply host sequencer.
// States are plain 3-bit constants so older tools can consume the same encoding.
package mmul_host_pkg;

    localparam int unsigned RES_W         = 16;
    localparam int unsigned BYTES_PER_RES = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_READ  = 3'd4;
    localparam state_t S_EMIT  = 3'd5;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmul_res_buffer.sv
// Result register file: byte-lane write from the serial readout, 16-bit read for the result stream.
module mmul_res_buffer
    import mmul_host_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wr_hi,
    input  logic [7:0]       wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [RES_W-1:0] rd_data
);

    logic [RES_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_hi) begin
                mem[wr_addr][15:8] <= wr_data;
            end else begin
                mem[wr_addr][7:0] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mmul_host_sequencer.sv
// Host-side initiator: streams operand beats onto the accelerator pins, collects the
// byte-serial results and re-emits them as 16-bit words on a valid/ready stream.
module mmul_host_sequencer
    import mmul_host_pkg::*;
#(
    parameter int unsigned COMPUTE_SLICES = 4,
    parameter int unsigned K_LEN          = 8,
    parameter int unsigned READ_LAT       = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              op_valid,
    output logic                              op_ready,
    input  logic [7:0]                        op_w,
    input  logic [7:0]                        op_x,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [15:0]                       res_data,
    output logic [$clog2(COMPUTE_SLICES)-1:0] res_idx,
    output logic                              res_last,
    output logic [7:0]                        acc_ui,
    output logic [7:0]                        acc_uio,
    input  logic [7:0]                        acc_uo,
    output logic                              acc_ena,
    output logic                              acc_rst_n
);

    localparam int unsigned READ_BYTES = BYTES_PER_RES * COMPUTE_SLICES;
    localparam int unsigned MAX_KR     = (K_LEN > READ_LAT) ? K_LEN : READ_LAT;
    localparam int unsigned CNT_MAX    = (MAX_KR > READ_BYTES) ? MAX_KR : READ_BYTES;
    localparam int unsigned CNT_W      = cnt_width(CNT_MAX);
    localparam int unsigned IDX_W      = cnt_width(COMPUTE_SLICES);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             ena_d;
    logic [7:0]       ui_d, uio_d;
    logic             wr_en;
    logic             op_hs, res_hs;

    assign op_ready  = (state == S_LOAD);
    assign res_valid = (state == S_EMIT);
    assign res_last  = res_valid && (idx == IDX_W'(COMPUTE_SLICES - 1));
    assign res_idx   = idx;
    assign op_hs     = op_valid && op_ready;
    assign res_hs    = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counters and the pin values launched on the next edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        ena_d      = 1'b0;
        ui_d       = 8'h00;
        uio_d      = 8'h00;
        wr_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_next   = '0;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                if (op_hs) begin
                    ena_d = 1'b1;
                    ui_d  = op_w;
                    uio_d = op_x;
                    if (cnt == CNT_W'(K_LEN - 1)) begin
                        cnt_next   = '0;
                        state_next = (READ_LAT > 1) ? S_WAIT : S_READ;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                ena_d = 1'b1;
                if (cnt == CNT_W'(READ_LAT - 2)) begin
                    cnt_next   = '0;
                    state_next = S_READ;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                ena_d = 1'b1;
                wr_en = 1'b1;
                if (cnt == CNT_W'(READ_BYTES - 1)) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = S_EMIT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (res_hs) begin
                    if (idx == IDX_W'(COMPUTE_SLICES - 1)) begin
                        idx_next   = '0;
                        state_next = op_valid ? S_CLEAR : S_IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pins are registered, so the accelerator sees each state's drive one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            acc_ena   <= 1'b0;
            acc_ui    <= 8'h00;
            acc_uio   <= 8'h00;
            acc_rst_n <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            idx       <= idx_next;
            acc_ena   <= ena_d;
            acc_ui    <= ui_d;
            acc_uio   <= uio_d;
            acc_rst_n <= (state != S_CLEAR);
        end
    end

    mmul_res_buffer #(
        .DEPTH (COMPUTE_SLICES),
        .AW    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (IDX_W'(cnt >> 1)),
        .wr_hi   (cnt[0]),
        .wr_data (acc_uo),
        .rd_addr (idx),
        .rd_data (res_data)
    );

endmodule

// File: doc/mmul_host_sequencer.md
# mmul_host_sequencer

Host-side initiator for the i4×i8 matrix-multiply accelerator. It takes operand beats from a local valid/ready stream and drives them onto the accelerator's dedicated and bidirectional input pins. It then captures the byte-serial results from the accelerator output pins and re-emits them as signed 16-bit words on a valid/ready result stream. It sits between the test/host fabric and the accelerator top, and is the transmit-and-collect counterpart of the accelerator pin interface.

## Interface
Parameters:
- COMPUTE_SLICES, 4: results per tile; must match the accelerator build.
- K_LEN, 8: operand beats per tile (dot-product length), ≥1.
- READ_LAT, 2: cycles from the last load beat to the first result byte on acc_uo, ≥1.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  operand beat accepted this cycle when op_valid is also high.
- op_w  in  8  two packed signed i4 weights: [3:0] and [7:4].
- op_x  in  8  signed i8 input.
- res_valid  out  1  result word valid.
- res_ready  in  1  result consumer ready.
- res_data  out  16  signed result.
- res_idx  out  $clog2(COMPUTE_SLICES)  slice index of res_data.
- res_last  out  1  marks the final result of the tile.
- acc_ui  out  8  to accelerator ui_in (weights).
- acc_uio  out  8  to accelerator uio_in (inputs).
- acc_uo  in  8  from accelerator uo_out (result bytes).
- acc_ena  out  1  accelerator advance/enable.
- acc_rst_n  out  1  accelerator active-low reset; also clears the accelerator accumulators.

## Operation
- FSM states: IDLE, CLEAR, LOAD, WAIT, READ, EMIT.
- IDLE → CLEAR when op_valid=1; op_ready stays 0 in IDLE.
- CLEAR lasts 1 cycle: acc_rst_n=0, acc_ena=0. Then → LOAD.
- LOAD:
  - op_ready=1.
  - On a handshake: acc_ui=op_w, acc_uio=op_x, acc_ena=1, and beat_cnt increments.
  - On a bubble (op_valid=0): acc_ui=acc_uio=0, acc_ena=0, and beat_cnt holds.
  - After handshake number K_LEN → WAIT. op_ready drops in the same cycle the state leaves LOAD.
- WAIT: acc_ena=1, pins driven to 0, for READ_LAT-1 cycles (0 cycles when READ_LAT=1). Then → READ.
- READ:
  - Lasts exactly 2*COMPUTE_SLICES cycles with acc_ena=1; the accelerator cannot stall.
  - Byte n of acc_uo is written into result buffer entry n/2: low byte when n is even, high byte when n is odd. Low byte arrives first.
  - Then → EMIT.
- EMIT:
  - Presents buffer entries idx 0..COMPUTE_SLICES-1 in order. res_last=1 on the final index.
  - Each entry is held stable until res_valid&&res_ready.
  - After the last handshake → CLEAR if op_valid=1 (back-to-back tiles), otherwise IDLE.
- Arithmetic: results are two's-complement 16-bit and passed through unmodified. The block does no sign extension or saturation.
- acc_rst_n=1 in every state except CLEAR and while rst is asserted.

## Timing
- Reset values (asynchronous, for the whole duration of rst):
  - state=IDLE, all counters 0, buffer 0.
  - op_ready=0, res_valid=0, res_data=0, res_idx=0, res_last=0.
  - acc_ui=0, acc_uio=0, acc_ena=0, acc_rst_n=0.
- All outputs are registered or decoded from the registered state; there is no combinational path from op_valid to op_ready.
- Minimum tile latency, from the first op_valid in IDLE to the first res_valid: 1 (CLEAR) + K_LEN + (READ_LAT-1) + 2*COMPUTE_SLICES + 1 cycles.
- Reset mid-tile: the partial tile is discarded. After release the block is in IDLE. The next tile's CLEAR state clears the accelerator.
- res_ready held at 0 in EMIT: the block stalls indefinitely; the buffer is not overwritten because READ cannot start before EMIT completes.
- op_valid asserted during WAIT, READ or EMIT: ignored, since op_ready=0.

## Structure
- Package mmul_host_pkg contains:
  - the state enum;
  - RES_W=16 and BYTES_PER_RES=2;
  - a function for the counter width.
- Sub-module mmul_res_buffer: COMPUTE_SLICES×16 register file with a byte-lane write port (addr, hi/lo select, 8-bit data) and a 16-bit read port. The FSM and counters stay in the top.

## Test plan
Defaults apply (COMPUTE_SLICES=4, K_LEN=8, READ_LAT=2). The bench uses a behavioural accelerator model that records pin beats and replays a programmed byte stream.
- Continuous stream: 8 beats with op_w=0x1F, op_x=0x80, op_valid always high → the model records exactly 8 beats with those values; acc_rst_n is low for exactly 1 cycle before the first beat.
- Readout assembly: the model drives bytes 34,12,CD,AB,00,80,FF,7F → results 0x1234, 0xABCD, 0x8000, 0x7FFF at idx 0..3, with res_last only on idx 3.
- Bubbles and stall: op_valid toggled 1/0 during LOAD → the model still sees 8 beats with acc_ena=0 on every bubble. res_ready held low for 10 cycles in EMIT → res_data and res_idx hold stable.
- Back-to-back tiles: op_valid already high during the last EMIT handshake → CLEAR follows in the very next cycle with no IDLE cycle, and the second tile's results are correct.
- Reset mid-LOAD after 3 beats → all outputs take their reset values asynchronously. The next tile is a clean 8-beat tile, and the model sees a CLEAR pulse before it.
